dma_bus_arbiter: RTL and testbench

//  Shares the single 16-bit memory bus (RAM/BIOS/cart + memoryMap) between the 6502C CPU and a
//  DMA requester (ANTIC display-list/playfield fetch). Steals bus cycles by raising the CPU HALT

---
 rtl/arb_pkg.sv | 14 +
 rtl/arb_sat_counter.sv | 23 ++
 rtl/dma_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_dma_bus_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encodings and bus widths for the DMA bus arbiter
package arb_pkg;

    localparam int ARB_AW = 16;
    localparam int ARB_DW = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_RD = 2'd1,
        DMA     = 2'd2,
        TURN    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/arb_sat_counter.sv
// rtl/arb_sat_counter.sv - clearable saturating up-counter
module arb_sat_counter #(
    parameter int W   = 4,
    parameter int MAX = 8
) (
    input  logic         clk,
    input  logic         RES_L,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge RES_L) begin
        if (!RES_L) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != W'(MAX))) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/dma_bus_arbiter.sv
// rtl/dma_bus_arbiter.sv - shares the memory bus between the CPU and a DMA fetcher by halting CPU reads
module dma_bus_arbiter
    import arb_pkg::*;
#(
    parameter int AW          = ARB_AW,
    parameter int DW          = ARB_DW,
    parameter int MAX_BURST   = 48,
    parameter int WRITE_LIMIT = 3
) (
    input  logic          clk,
    input  logic          RES_L,
    input  logic          cyc_en,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_dout,
    input  logic          cpu_RW,
    output logic          HALT,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    output logic          dma_ack,
    output logic [DW-1:0] dma_data,
    output logic          dma_dvalid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic [DW-1:0] cpu_din,
    output logic          bus_owner,
    output logic          arb_err
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int WW = $clog2(WRITE_LIMIT + 2);

    arb_state_t    state;
    logic [BW-1:0] burst_cnt;
    logic [WW-1:0] wr_cnt;
    logic [AW-1:0] dma_addr_q;
    logic          grant;
    logic          burst_clr;
    logic          wr_inc;
    logic          wr_clr;

    // grant: this strobe hands the following bus cycle to the DMA requester
    always_comb begin
        grant = 1'b0;
        if (cyc_en && dma_req) begin
            if (state == WAIT_RD) begin
                grant = cpu_RW;
            end else if (state == DMA) begin
                grant = (burst_cnt != BW'(MAX_BURST));
            end
        end
    end

    assign burst_clr = cyc_en && ((state == TURN) || (state == IDLE));
    assign wr_inc    = cyc_en && (state == WAIT_RD) && dma_req && !cpu_RW;
    assign wr_clr    = cyc_en && (state != WAIT_RD);

    arb_sat_counter #(.W(BW), .MAX(MAX_BURST)) u_burst_cnt (
        .clk   (clk),
        .RES_L (RES_L),
        .clr   (burst_clr),
        .inc   (grant),
        .cnt   (burst_cnt)
    );

    arb_sat_counter #(.W(WW), .MAX(WRITE_LIMIT + 1)) u_wr_cnt (
        .clk   (clk),
        .RES_L (RES_L),
        .clr   (wr_clr),
        .inc   (wr_inc),
        .cnt   (wr_cnt)
    );

    always_ff @(posedge clk or negedge RES_L) begin
        if (!RES_L) begin
            state      <= IDLE;
            HALT       <= 1'b0;
            bus_owner  <= 1'b0;
            dma_ack    <= 1'b0;
            dma_dvalid <= 1'b0;
            dma_data   <= '0;
            dma_addr_q <= '0;
            arb_err    <= 1'b0;
        end else begin
            dma_ack    <= grant;
            // every DMA bus cycle was acked, so its byte is captured on the strobe that ends it
            dma_dvalid <= cyc_en && (state == DMA);
            if (cyc_en && (state == DMA)) begin
                dma_data <= mem_dout;
            end
            if (grant) begin
                dma_addr_q <= dma_addr;
            end
            if (cyc_en) begin
                case (state)
                    IDLE: begin
                        if (dma_req) begin
                            state <= WAIT_RD;
                            HALT  <= 1'b1;
                        end
                    end
                    WAIT_RD: begin
                        if (!dma_req) begin
                            state <= IDLE;
                            HALT  <= 1'b0;
                        end else if (cpu_RW) begin
                            state     <= DMA;
                            bus_owner <= 1'b1;
                        end else if (wr_cnt >= WW'(WRITE_LIMIT)) begin
                            arb_err <= 1'b1;
                        end
                    end
                    DMA: begin
                        if (!grant) begin
                            state     <= TURN;
                            HALT      <= 1'b0;
                            bus_owner <= 1'b0;
                        end
                    end
                    TURN: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign mem_addr = bus_owner ? dma_addr_q : cpu_addr;
    assign mem_we   = RES_L && !bus_owner && !cpu_RW;
    assign mem_din  = cpu_dout;
    assign cpu_din  = mem_dout;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb/tb_dma_bus_arbiter.sv - directed vector bench for dma_bus_arbiter
module tb_dma_bus_arbiter;

    logic        clk;
    logic        RES_L;
    logic        cyc_en;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_RW;
    logic        HALT;
    logic        dma_req;
    logic [15:0] dma_addr;
    logic        dma_ack;
    logic [7:0]  dma_data;
    logic        dma_dvalid;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [7:0]  cpu_din;
    logic        bus_owner;
    logic        arb_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:65535];

    dma_bus_arbiter #(
        .AW(16), .DW(8), .MAX_BURST(4), .WRITE_LIMIT(3)
    ) dut (
        .clk        (clk),
        .RES_L      (RES_L),
        .cyc_en     (cyc_en),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_RW     (cpu_RW),
        .HALT       (HALT),
        .dma_req    (dma_req),
        .dma_addr   (dma_addr),
        .dma_ack    (dma_ack),
        .dma_data   (dma_data),
        .dma_dvalid (dma_dvalid),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .cpu_din    (cpu_din),
        .bus_owner  (bus_owner),
        .arb_err    (arb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    typedef struct {
        logic        rst;
        logic [15:0] a;
        logic        rw;
        logic [7:0]  d;
        logic        req;
        logic [15:0] da;
        logic        halt;
        logic        own;
        logic        ack;
        logic        dv;
        logic [7:0]  data;
        logic [15:0] maddr;
        logic        we;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic [15:0] a, input logic rw,
                                input logic [7:0] d, input logic req, input logic [15:0] da,
                                input logic halt, input logic own, input logic ack, input logic dv,
                                input logic [7:0] data, input logic [15:0] maddr,
                                input logic we, input logic err);
        vec_t v;
        v.rst = rst; v.a = a; v.rw = rw; v.d = d; v.req = req; v.da = da;
        v.halt = halt; v.own = own; v.ack = ack; v.dv = dv; v.data = data;
        v.maddr = maddr; v.we = we; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        cyc_en = 1'b0;
        RES_L  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        RES_L = 1'b1;
    endtask

    // one CPU bus cycle: drive inputs, strobe, then sample #1 after the strobe edge
    task automatic step(input logic [15:0] a, input logic rw, input logic [7:0] d,
                        input logic req, input logic [15:0] da);
        cpu_addr = a; cpu_RW = rw; cpu_dout = d; dma_req = req; dma_addr = da;
        @(negedge clk);
        @(negedge clk);
        cyc_en = 1'b1;
        @(posedge clk);
        #1;
        cyc_en = 1'b0;
    endtask

    int acks;

    initial begin
        RES_L = 1'b0; cyc_en = 1'b0; cpu_addr = '0; cpu_dout = '0; cpu_RW = 1'b1;
        dma_req = 1'b0; dma_addr = '0;

        //             rst a        rw d      req da       halt own ack dv data   maddr    we err
        vecs.push_back(mk(1, 16'h1000, 1, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h1000, 0, 0));
        vecs.push_back(mk(0, 16'h9C20, 0, 8'hA5, 0, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h9C20, 1, 0));
        vecs.push_back(mk(0, 16'h9C21, 0, 8'h3C, 0, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h9C21, 1, 0));
        vecs.push_back(mk(0, 16'h1001, 1, 8'h00, 1, 16'h9C20, 1, 0, 0, 0, 8'h00, 16'h1001, 0, 0));
        vecs.push_back(mk(0, 16'h1002, 1, 8'h00, 1, 16'h9C20, 1, 1, 1, 0, 8'h00, 16'h9C20, 0, 0));
        vecs.push_back(mk(0, 16'h1002, 1, 8'h00, 0, 16'h0000, 0, 0, 0, 1, 8'hA5, 16'h1002, 0, 0));
        vecs.push_back(mk(0, 16'h1002, 1, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h1002, 0, 0));
        vecs.push_back(mk(0, 16'h01FF, 0, 8'h11, 1, 16'h9C21, 1, 0, 0, 0, 8'h00, 16'h01FF, 1, 0));
        vecs.push_back(mk(0, 16'h01FE, 0, 8'h22, 1, 16'h9C21, 1, 0, 0, 0, 8'h00, 16'h01FE, 1, 0));
        vecs.push_back(mk(0, 16'h01FD, 0, 8'h33, 1, 16'h9C21, 1, 0, 0, 0, 8'h00, 16'h01FD, 1, 0));
        vecs.push_back(mk(0, 16'h2000, 1, 8'h00, 1, 16'h9C21, 1, 1, 1, 0, 8'h00, 16'h9C21, 0, 0));
        vecs.push_back(mk(0, 16'h2000, 1, 8'h00, 1, 16'h01FF, 1, 1, 1, 1, 8'h3C, 16'h01FF, 0, 0));
        vecs.push_back(mk(0, 16'h2000, 1, 8'h00, 0, 16'h0000, 0, 0, 0, 1, 8'h11, 16'h2000, 0, 0));
        vecs.push_back(mk(0, 16'h2000, 1, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h2000, 0, 0));
        vecs.push_back(mk(0, 16'h0300, 0, 8'h44, 1, 16'h0000, 1, 0, 0, 0, 8'h00, 16'h0300, 1, 0));
        vecs.push_back(mk(0, 16'h0301, 0, 8'h55, 0, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h0301, 1, 0));
        vecs.push_back(mk(0, 16'h0302, 1, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h0302, 0, 0));
        vecs.push_back(mk(0, 16'h01F0, 1, 8'h00, 1, 16'h0000, 1, 0, 0, 0, 8'h00, 16'h01F0, 0, 0));
        vecs.push_back(mk(0, 16'h01F0, 0, 8'h01, 1, 16'h0000, 1, 0, 0, 0, 8'h00, 16'h01F0, 1, 0));
        vecs.push_back(mk(0, 16'h01EF, 0, 8'h02, 1, 16'h0000, 1, 0, 0, 0, 8'h00, 16'h01EF, 1, 0));
        vecs.push_back(mk(0, 16'h01EE, 0, 8'h03, 1, 16'h0000, 1, 0, 0, 0, 8'h00, 16'h01EE, 1, 0));
        vecs.push_back(mk(0, 16'h01ED, 0, 8'h04, 1, 16'h0000, 1, 0, 0, 0, 8'h00, 16'h01ED, 1, 1));
        vecs.push_back(mk(0, 16'h0400, 1, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h0400, 0, 1));
        vecs.push_back(mk(0, 16'h0400, 1, 8'h00, 1, 16'h0000, 1, 0, 0, 0, 8'h00, 16'h0400, 0, 1));
        vecs.push_back(mk(0, 16'h0400, 1, 8'h00, 1, 16'h9C20, 1, 1, 1, 0, 8'h00, 16'h9C20, 0, 1));
        vecs.push_back(mk(0, 16'h0400, 1, 8'h00, 0, 16'h0000, 0, 0, 0, 1, 8'hA5, 16'h0400, 0, 1));
        vecs.push_back(mk(1, 16'h1000, 1, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h1000, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) begin
                do_reset();
                chk($sformatf("v%0d reset halt", i), {31'b0, HALT}, 32'd0);
                chk($sformatf("v%0d reset dma_data", i), {24'b0, dma_data}, 32'd0);
            end
            step(vecs[i].a, vecs[i].rw, vecs[i].d, vecs[i].req, vecs[i].da);
            chk($sformatf("v%0d HALT", i), {31'b0, HALT}, {31'b0, vecs[i].halt});
            chk($sformatf("v%0d bus_owner", i), {31'b0, bus_owner}, {31'b0, vecs[i].own});
            chk($sformatf("v%0d dma_ack", i), {31'b0, dma_ack}, {31'b0, vecs[i].ack});
            chk($sformatf("v%0d dma_dvalid", i), {31'b0, dma_dvalid}, {31'b0, vecs[i].dv});
            if (vecs[i].dv)
                chk($sformatf("v%0d dma_data", i), {24'b0, dma_data}, {24'b0, vecs[i].data});
            chk($sformatf("v%0d mem_addr", i), {16'b0, mem_addr}, {16'b0, vecs[i].maddr});
            chk($sformatf("v%0d mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].we});
            chk($sformatf("v%0d arb_err", i), {31'b0, arb_err}, {31'b0, vecs[i].err});
            chk($sformatf("v%0d mem_din", i), {24'b0, mem_din}, {24'b0, vecs[i].d});
        end

        chk("deferred write 01FE", {24'b0, mem[16'h01FE]}, 32'h22);
        chk("deferred write 01FD", {24'b0, mem[16'h01FD]}, 32'h33);
        chk("cpu_din passthrough", {24'b0, cpu_din}, {24'b0, mem_dout});

        // asynchronous reset in the middle of a burst, between strobes
        do_reset();
        step(16'h1000, 1, 8'h00, 1, 16'h9C20);
        step(16'h1000, 1, 8'h00, 1, 16'h9C20);
        step(16'h1000, 1, 8'h00, 1, 16'h9C21);
        chk("midburst dvalid before reset", {31'b0, dma_dvalid}, 32'd1);
        chk("midburst owner before reset", {31'b0, bus_owner}, 32'd1);
        cpu_RW = 1'b0;
        #2;
        RES_L = 1'b0;
        #1;
        chk("async reset HALT", {31'b0, HALT}, 32'd0);
        chk("async reset bus_owner", {31'b0, bus_owner}, 32'd0);
        chk("async reset dma_dvalid", {31'b0, dma_dvalid}, 32'd0);
        chk("async reset mem_we", {31'b0, mem_we}, 32'd0);
        chk("async reset dma_data", {24'b0, dma_data}, 32'd0);
        @(negedge clk);
        RES_L = 1'b1;

        // burst limit of 4 with the request held throughout
        step(16'h3000, 1, 8'h00, 1, 16'h9C20);
        chk("burst WAIT_RD HALT", {31'b0, HALT}, 32'd1);
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            step(16'h3000, 1, 8'h00, 1, 16'h9C20);
            if (dma_ack) acks++;
            chk($sformatf("burst beat %0d owner", k), {31'b0, bus_owner}, 32'd1);
        end
        chk("burst ack count", acks, 32'd4);
        step(16'h3000, 1, 8'h00, 1, 16'h9C20);
        chk("burst TURN HALT", {31'b0, HALT}, 32'd0);
        chk("burst TURN ack", {31'b0, dma_ack}, 32'd0);
        chk("burst TURN final dvalid", {31'b0, dma_dvalid}, 32'd1);
        chk("burst TURN mem_addr", {16'b0, mem_addr}, 32'h3000);
        step(16'h3001, 1, 8'h00, 1, 16'h9C20);
        chk("burst IDLE HALT", {31'b0, HALT}, 32'd0);
        step(16'h3002, 1, 8'h00, 1, 16'h9C20);
        chk("burst re-request HALT", {31'b0, HALT}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
